uart_rx_fsm: RTL

UART_RX_FSM -- requirements
Module: uart_rx_fsm

---
 rtl/uart_rx_fsm.sv | 199 +++++++++++++++++++
 1 files changed

// File: rtl/uart_rx_fsm.sv
// UART receive control FSM: tracks bit and edge position within a frame,
// strobes the sampler/checkers and reports frame completion or error.
module uart_rx_fsm #(
    parameter int PRESCALE_W = 6
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  RX_IN,
    input  logic                  PAR_EN,
    input  logic [PRESCALE_W-1:0] PRESCALE,
    input  logic                  par_err,
    input  logic                  strt_glitch,
    input  logic                  stp_err,
    output logic [PRESCALE_W-1:0] edge_cnt,
    output logic [3:0]            bit_cnt,
    output logic                  dat_samp_en,
    output logic                  deser_en,
    output logic                  strt_chk_en,
    output logic                  par_chk_en,
    output logic                  stp_chk_en,
    output logic                  data_valid,
    output logic                  frame_err
);

    localparam logic [2:0] IDLE   = 3'd0;
    localparam logic [2:0] START  = 3'd1;
    localparam logic [2:0] DATA   = 3'd2;
    localparam logic [2:0] PARITY = 3'd3;
    localparam logic [2:0] STOP   = 3'd4;

    localparam logic [PRESCALE_W-1:0] P_ONE  = PRESCALE_W'(1);
    localparam logic [PRESCALE_W-1:0] P_FOUR = PRESCALE_W'(4);
    localparam logic [PRESCALE_W-1:0] P_DFLT = PRESCALE_W'(8);

    logic [2:0]            state_q, state_d;
    logic [PRESCALE_W-1:0] edge_q, edge_d;
    logic [3:0]            bit_q, bit_d;
    logic [PRESCALE_W-1:0] presc_q, presc_d;
    logic                  par_en_q, par_en_d;
    logic                  par_flag_q, par_flag_d;

    logic samp_q, samp_d;
    logic deser_q, deser_d;
    logic strt_chk_q, strt_chk_d;
    logic par_chk_q, par_chk_d;
    logic stp_chk_q, stp_chk_d;
    logic dv_q, dv_d;
    logic fe_q, fe_d;

    logic                  bit_end;
    logic [PRESCALE_W-1:0] presc_legal;
    logic [PRESCALE_W-1:0] half;
    logic                  active_d;
    logic                  chk_pt;

    assign bit_end     = (edge_q == presc_q);
    assign presc_legal = (PRESCALE < P_FOUR) ? P_DFLT : PRESCALE;

    // Next-state logic: frame position tracking and end-of-frame verdict
    always_comb begin
        state_d    = state_q;
        edge_d     = edge_q;
        bit_d      = bit_q;
        presc_d    = presc_q;
        par_en_d   = par_en_q;
        par_flag_d = par_flag_q;
        dv_d       = 1'b0;
        fe_d       = 1'b0;

        if (state_q != IDLE) begin
            if (bit_end) begin
                edge_d = P_ONE;
                bit_d  = bit_q + 4'd1;
            end else begin
                edge_d = edge_q + P_ONE;
            end
        end

        unique case (state_q)
            IDLE: begin
                edge_d = '0;
                bit_d  = 4'd0;
                if (!RX_IN) begin
                    state_d    = START;
                    edge_d     = P_ONE;
                    bit_d      = 4'd0;
                    presc_d    = presc_legal;
                    par_en_d   = PAR_EN;
                    par_flag_d = 1'b0;
                end
            end
            START: begin
                if (bit_end) begin
                    if (strt_glitch) begin
                        state_d = IDLE;
                        edge_d  = '0;
                        bit_d   = 4'd0;
                    end else begin
                        state_d = DATA;
                    end
                end
            end
            DATA: begin
                if (bit_end && (bit_q == 4'd8)) begin
                    state_d = par_en_q ? PARITY : STOP;
                end
            end
            PARITY: begin
                if (bit_end) begin
                    par_flag_d = par_flag_q | par_err;
                    state_d    = STOP;
                end
            end
            STOP: begin
                if (bit_end) begin
                    state_d = IDLE;
                    edge_d  = '0;
                    bit_d   = 4'd0;
                    if (!stp_err && !par_flag_q) begin
                        dv_d = 1'b1;
                    end else begin
                        fe_d = 1'b1;
                    end
                end
            end
            default: begin
                state_d = IDLE;
                edge_d  = '0;
                bit_d   = 4'd0;
            end
        endcase
    end

    // Output decode from next-state values so registered strobes line up with edge_cnt
    always_comb begin
        half       = presc_d >> 1;
        active_d   = (state_d != IDLE);
        chk_pt     = (edge_d == (presc_d - P_ONE));
        samp_d     = active_d &&
                     ((edge_d == (half - P_ONE)) ||
                      (edge_d == half) ||
                      (edge_d == (half + P_ONE)));
        deser_d    = (state_d == DATA);
        strt_chk_d = (state_d == START) && chk_pt;
        par_chk_d  = (state_d == PARITY) && chk_pt;
        stp_chk_d  = (state_d == STOP) && chk_pt;
    end

    // Frame control state
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q    <= IDLE;
            edge_q     <= '0;
            bit_q      <= 4'd0;
            presc_q    <= P_DFLT;
            par_en_q   <= 1'b0;
            par_flag_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            edge_q     <= edge_d;
            bit_q      <= bit_d;
            presc_q    <= presc_d;
            par_en_q   <= par_en_d;
            par_flag_q <= par_flag_d;
        end
    end

    // Registered enables and completion pulses
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            samp_q     <= 1'b0;
            deser_q    <= 1'b0;
            strt_chk_q <= 1'b0;
            par_chk_q  <= 1'b0;
            stp_chk_q  <= 1'b0;
            dv_q       <= 1'b0;
            fe_q       <= 1'b0;
        end else begin
            samp_q     <= samp_d;
            deser_q    <= deser_d;
            strt_chk_q <= strt_chk_d;
            par_chk_q  <= par_chk_d;
            stp_chk_q  <= stp_chk_d;
            dv_q       <= dv_d;
            fe_q       <= fe_d;
        end
    end

    assign edge_cnt    = edge_q;
    assign bit_cnt     = bit_q;
    assign dat_samp_en = samp_q;
    assign deser_en    = deser_q;
    assign strt_chk_en = strt_chk_q;
    assign par_chk_en  = par_chk_q;
    assign stp_chk_en  = stp_chk_q;
    assign data_valid  = dv_q;
    assign frame_err   = fe_q;

endmodule
